// File: rtl/parking_pkg.sv
// Shared encodings for the parking gate arbiter.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } state_t;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// Lane request / gate actuator bundle; slave side is the arbiter.
interface parking_gate_arbiter_if #(
  parameter int unsigned N = 4
);

  logic         req_in;
  logic         req_out;
  logic         car_passed;
  logic         grant_in;
  logic         grant_out;
  logic         gate_open;
  logic [N-1:0] occupancy;
  logic         full;
  logic         timeout_err;

  modport master (
    output req_in, req_out, car_passed,
    input  grant_in, grant_out, gate_open, occupancy, full, timeout_err
  );

  modport slave (
    input  req_in, req_out, car_passed,
    output grant_in, grant_out, gate_open, occupancy, full, timeout_err
  );

endinterface

// File: rtl/gate_timer.sv
// Loadable down-counter that bounds how long the gate waits for a pass.
module gate_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load on grant, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shared entry/exit barrier controller with round-robin arbitration and occupancy tracking.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned CAPACITY    = 10,
  parameter int unsigned OPEN_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  parking_gate_arbiter_if.slave bus
);

  localparam int unsigned TW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

  state_t       state;
  state_t       state_next;
  logic         dir;
  logic         last;
  logic         grant;
  logic         grant_dir;
  logic         timer_zero;
  logic         is_full;
  logic         eligible_in;
  logic         eligible_out;
  logic [N-1:0] occupancy;
  logic         timeout_err;

  assign is_full      = (occupancy == N'(CAPACITY));
  assign eligible_in  = bus.req_in && !is_full;
  assign eligible_out = bus.req_out && (occupancy != '0);

  gate_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (grant),
    .load_value (TW'(OPEN_CYCLES - 1)),
    .en         (state == OPEN),
    .zero       (timer_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and grant selection; a tie goes to the lane not served last.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_dir  = DIR_IN;
    case (state)
      IDLE: begin
        if (eligible_in || eligible_out) begin
          grant      = 1'b1;
          state_next = OPEN;
          if (eligible_in && eligible_out) begin
            grant_dir = (last == DIR_IN) ? DIR_OUT : DIR_IN;
          end else begin
            grant_dir = eligible_out ? DIR_OUT : DIR_IN;
          end
        end
      end
      OPEN: begin
        if (bus.car_passed || timer_zero) begin
          state_next = CLOSE;
        end
      end
      CLOSE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gate and grant outputs decoded from the state register.
  always_comb begin
    bus.gate_open = 1'b0;
    bus.grant_in  = 1'b0;
    bus.grant_out = 1'b0;
    if (state == OPEN) begin
      bus.gate_open = 1'b1;
      bus.grant_in  = (dir == DIR_IN);
      bus.grant_out = (dir == DIR_OUT);
    end
  end

  // Lane bookkeeping, occupancy update on a pass, timeout pulse into CLOSE.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir         <= DIR_IN;
      last        <= DIR_IN;
      occupancy   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= (state == OPEN) && !bus.car_passed && timer_zero;
      if (grant) begin
        dir  <= grant_dir;
        last <= grant_dir;
      end
      if ((state == OPEN) && bus.car_passed) begin
        occupancy <= (dir == DIR_IN) ? occupancy + N'(1) : occupancy - N'(1);
      end
    end
  end

  assign bus.occupancy   = occupancy;
  assign bus.full        = is_full;
  assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Randomized and directed checks of the parking gate arbiter against a transaction-level model.
module tb_parking_gate_arbiter;

  localparam int unsigned N           = 4;
  localparam int unsigned CAPACITY    = 10;
  localparam int unsigned OPEN_CYCLES = 8;

  logic clk = 1'b0;
  logic reset;

  parking_gate_arbiter_if #(.N(N)) bus ();

  parking_gate_arbiter #(
    .N           (N),
    .CAPACITY    (CAPACITY),
    .OPEN_CYCLES (OPEN_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: gate is either closed-waiting, serving a lane with some cycles left, or cooling down.
  bit serving;
  bit cooling;
  int lane;       // 0 entry, 1 exit
  int prev_lane;
  int cars;
  int cycles_left;
  bit expired;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    serving = 0; cooling = 0; lane = 0; prev_lane = 0;
    cars = 0; cycles_left = 0; expired = 0;
  endtask

  task automatic model_step(input bit ri, input bit ro, input bit cp, input bit rs);
    bit want_in, want_out;
    if (rs) begin
      model_reset();
      return;
    end
    expired = 0;
    if (serving) begin
      if (cp) begin
        cars    = (lane == 0) ? cars + 1 : cars - 1;
        serving = 0;
        cooling = 1;
      end else if (cycles_left == 1) begin
        expired = 1;
        serving = 0;
        cooling = 1;
      end else begin
        cycles_left--;
      end
    end else if (cooling) begin
      cooling = 0;
    end else begin
      want_in  = ri && (cars < CAPACITY);
      want_out = ro && (cars > 0);
      if (want_in || want_out) begin
        if (want_in && want_out) lane = 1 - prev_lane;
        else                     lane = want_out ? 1 : 0;
        prev_lane   = lane;
        serving     = 1;
        cycles_left = OPEN_CYCLES;
      end
    end
  endtask

  task automatic compare_all();
    check("gate_open",   32'(bus.gate_open),   32'(serving));
    check("grant_in",    32'(bus.grant_in),    32'(serving && lane == 0));
    check("grant_out",   32'(bus.grant_out),   32'(serving && lane == 1));
    check("occupancy",   32'(bus.occupancy),   32'(cars));
    check("full",        32'(bus.full),        32'(cars == CAPACITY));
    check("timeout_err", 32'(bus.timeout_err), 32'(expired));
  endtask

  // One clock: drive at negedge, model on posedge, compare at next negedge.
  task automatic cyc(input bit ri, input bit ro, input bit cp, input bit rs);
    bus.req_in     = ri;
    bus.req_out    = ro;
    bus.car_passed = cp;
    reset          = rs;
    @(posedge clk);
    model_step(ri, ro, cp, rs);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_grant(input bit ri, input bit ro);
    int n = 0;
    while (!serving && n < 20) begin
      cyc(ri, ro, 0, 0);
      n++;
    end
    if (!serving) check("grant_wait", 32'(bus.gate_open), 32'd1);
  endtask

  // Request, pass the car on the first open cycle, then return to idle.
  task automatic serve(input bit ri, input bit ro, output bit granted_out);
    wait_grant(ri, ro);
    granted_out = bus.grant_out;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    bit g;
    int opens, pulses;
    model_reset();
    bus.req_in = 0; bus.req_out = 0; bus.car_passed = 0; reset = 1;
    @(negedge clk);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Single entry, pass after three open cycles.
    cyc(1, 0, 0, 0);
    check("s1_grant_in", 32'(bus.grant_in), 32'd1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    check("s1_occ", 32'(bus.occupancy), 32'd1);
    check("s1_closed", 32'(bus.gate_open), 32'd0);
    cyc(0, 0, 0, 0);

    // Fill to 5, then contend: exit first, then strict alternation.
    while (cars < 5) serve(1, 0, g);
    serve(1, 1, g); check("rr_0", 32'(g), 32'd1);
    serve(1, 1, g); check("rr_1", 32'(g), 32'd0);
    serve(1, 1, g); check("rr_2", 32'(g), 32'd1);
    serve(1, 1, g); check("rr_3", 32'(g), 32'd0);
    check("rr_occ", 32'(bus.occupancy), 32'd5);

    // Full lot blocks entry; exit served, then entry.
    while (cars < CAPACITY) serve(1, 0, g);
    check("full_set", 32'(bus.full), 32'd1);
    repeat (3) cyc(1, 0, 0, 0);
    check("full_blocks", 32'(bus.gate_open), 32'd0);
    serve(1, 1, g); check("full_exit", 32'(g), 32'd1);
    check("full_drop", 32'(bus.full), 32'd0);
    check("occ_9", 32'(bus.occupancy), 32'd9);
    serve(1, 1, g); check("full_then_in", 32'(g), 32'd0);

    // Timeout: window of exactly OPEN_CYCLES and a single pulse.
    wait_grant(0, 1);
    opens = 0; pulses = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.gate_open) opens++;
      if (bus.timeout_err) pulses++;
      cyc(0, 0, 0, 0);
    end
    check("to_open_len", 32'(opens), 32'(OPEN_CYCLES));
    check("to_pulses", 32'(pulses), 32'd1);
    check("to_occ", 32'(bus.occupancy), 32'd10);

    // Pass on the final open cycle beats the timeout.
    wait_grant(0, 1);
    repeat (OPEN_CYCLES - 1) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    check("last_pass_to", 32'(bus.timeout_err), 32'd0);
    check("last_pass_occ", 32'(bus.occupancy), 32'd9);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    check("idle_pass_ignored", 32'(bus.occupancy), 32'd9);

    // Reset in the middle of an open window.
    while (cars > 3) serve(0, 1, g);
    wait_grant(1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    check("rst_gate", 32'(bus.gate_open), 32'd0);
    check("rst_grant", 32'(bus.grant_in), 32'd0);
    check("rst_occ", 32'(bus.occupancy), 32'd0);
    cyc(0, 0, 0, 0);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
